// File: rtl/pll_rst_seq_pkg.sv
// ---------------------------------------------------------------------------
// pll_rst_seq_pkg
//   Shared types and constants for the PLL reset sequencer.
//   - rst_state_t  : sequencer states
//   - LOSS_CNT_W   : width of the lock-loss event counter
//   - LOSS_CNT_MAX : saturation value of that counter
//   - cnt_width()  : width of the shared STABLE/POWERUP counter
//   - sat_inc()    : saturating increment for the lock-loss counter
// ---------------------------------------------------------------------------
package pll_rst_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        POWERUP   = 2'd2,
        RUN       = 2'd3
    } rst_state_t;

    localparam int                    LOSS_CNT_W   = 8;
    localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = 8'd255;

    // Enough bits to hold (max - 1); never less than one bit so that the
    // degenerate 1-cycle windows still produce a legal vector.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
        return (v == LOSS_CNT_MAX) ? v : v + LOSS_CNT_W'(1);
    endfunction

endpackage : pll_rst_seq_pkg

// File: rtl/pll_rst_seq_if.sv
// ---------------------------------------------------------------------------
// pll_rst_seq_if
//   Bundles the PLL lock input, the debug clear and the reset/init outputs
//   of the sequencer. Clock and reset stay plain ports on the modules.
//   master : environment side (drives locked, clear_lost)
//   slave  : sequencer side  (drives sys_rst_n, sdram_init_start, ready,
//                             lock_lost, lock_loss_count)
// ---------------------------------------------------------------------------
interface pll_rst_seq_if
    import pll_rst_seq_pkg::*;
();

    logic                  locked;
    logic                  clear_lost;
    logic                  sys_rst_n;
    logic                  sdram_init_start;
    logic                  ready;
    logic                  lock_lost;
    logic [LOSS_CNT_W-1:0] lock_loss_count;

    modport master (
        output locked,
        output clear_lost,
        input  sys_rst_n,
        input  sdram_init_start,
        input  ready,
        input  lock_lost,
        input  lock_loss_count
    );

    modport slave (
        input  locked,
        input  clear_lost,
        output sys_rst_n,
        output sdram_init_start,
        output ready,
        output lock_lost,
        output lock_loss_count
    );

endinterface : pll_rst_seq_if

// File: rtl/pll_rst_seq_sync_ff.sv
// ---------------------------------------------------------------------------
// sync_ff
//   Generic multi-flop synchronizer for a single asynchronous bit.
//   Ports:
//     clk   - destination clock
//     rst_n - synchronous active-low reset, clears every stage to 0
//     d     - asynchronous input
//     q     - synchronized output (STAGES edges of latency)
// ---------------------------------------------------------------------------
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // NOTE: every synchronizer stage is reset, not just the last one; an
    // un-reset middle stage could release a stale 1 right after reset and
    // skip the stability window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule : sync_ff

// File: rtl/pll_rst_seq.sv
// ---------------------------------------------------------------------------
// pll_rst_seq
//   Consumer end of the PLL lock interface. Holds the system in reset until
//   the synchronized lock has been high for STABLE_CYCLES, waits out the
//   SDRAM power-up interval, then pulses the SDRAM init request. Lock drops
//   after reset release are counted as loss events for debug.
//   Ports:
//     CLOCK_100 - sole clock (PLL output)
//     reset_n   - synchronous active-low reset
//     bus       - slave side of pll_rst_seq_if:
//                 locked (async in), clear_lost (in),
//                 sys_rst_n, sdram_init_start, ready, lock_lost,
//                 lock_loss_count (all registered outputs)
// ---------------------------------------------------------------------------
module pll_rst_seq
    import pll_rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 1024,
    parameter int POWERUP_CYCLES = 28000,
    parameter int CNT_W          = cnt_width(STABLE_CYCLES, POWERUP_CYCLES)
) (
    input  logic         CLOCK_100,
    input  logic         reset_n,
    pll_rst_seq_if.slave bus
);

    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] POWERUP_LAST = CNT_W'(POWERUP_CYCLES - 1);

    logic                  lock_s;

    rst_state_t            state_q;
    rst_state_t            state_nxt;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_nxt;
    logic                  loss;
    logic                  init_nxt;

    logic                  sys_rst_n_q;
    logic                  init_q;
    logic                  ready_q;
    logic                  lost_q;
    logic [LOSS_CNT_W-1:0] loss_cnt_q;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (CLOCK_100),
        .rst_n (reset_n),
        .d     (bus.locked),
        .q     (lock_s)
    );

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of the block so no
    // path through the case leaves one unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state_q;
        loss      = 1'b0;
        init_nxt  = 1'b0;

        unique case (state_q)
            WAIT_LOCK: begin
                if (lock_s) state_nxt = STABLE;
            end
            STABLE: begin
                // A drop here is a glitch before reset release, not a loss.
                if (!lock_s)                   state_nxt = WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_nxt = POWERUP;
            end
            POWERUP: begin
                // Loss is tested first so a drop on the terminal cycle
                // suppresses the init pulse.
                if (!lock_s) begin
                    loss      = 1'b1;
                    state_nxt = WAIT_LOCK;
                end else if (cnt_q == POWERUP_LAST) begin
                    state_nxt = RUN;
                    init_nxt  = 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    loss      = 1'b1;
                    state_nxt = WAIT_LOCK;
                end
            end
            default: state_nxt = WAIT_LOCK;
        endcase

        // Shared counter: restarts on every state change and only runs in
        // the two timed states. Terminal counts always leave the state, so
        // it never wraps.
        if (state_nxt != state_q) begin
            cnt_nxt = '0;
        end else if (state_q == STABLE || state_q == POWERUP) begin
            cnt_nxt = cnt_q + CNT_W'(1);
        end else begin
            cnt_nxt = '0;
        end
    end

    // -----------------------------------------------------------------------
    // State, counter and registered outputs
    // -----------------------------------------------------------------------
    // NOTE: non-blocking assignments throughout so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge CLOCK_100) begin
        if (!reset_n) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            sys_rst_n_q <= 1'b0;
            init_q      <= 1'b0;
            ready_q     <= 1'b0;
            lost_q      <= 1'b0;
            loss_cnt_q  <= '0;
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            // Outputs are decoded from the next state so they change on the
            // same edge as the state itself, with no output-side latency.
            sys_rst_n_q <= (state_nxt == POWERUP) || (state_nxt == RUN);
            ready_q     <= (state_nxt == RUN);
            init_q      <= init_nxt;

            // A loss in the same cycle as a clear wins: the clear zeroes the
            // old count and the loss is the first new one.
            if (loss) begin
                lost_q     <= 1'b1;
                loss_cnt_q <= bus.clear_lost ? LOSS_CNT_W'(1) : sat_inc(loss_cnt_q);
            end else if (bus.clear_lost) begin
                lost_q     <= 1'b0;
                loss_cnt_q <= '0;
            end
        end
    end

    assign bus.sys_rst_n        = sys_rst_n_q;
    assign bus.sdram_init_start = init_q;
    assign bus.ready            = ready_q;
    assign bus.lock_lost        = lost_q;
    assign bus.lock_loss_count  = loss_cnt_q;

endmodule : pll_rst_seq

// File: tb/tb_pll_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_pll_rst_seq
//   Self-checking bench for pll_rst_seq with SYNC_STAGES=2, STABLE_CYCLES=4,
//   POWERUP_CYCLES=8. Inputs change on the falling edge; outputs are
//   sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_pll_rst_seq;
    import pll_rst_seq_pkg::*;

    localparam int SYNC    = 2;
    localparam int STABLE_N = 4;
    localparam int POWER_N  = 8;
    // Edge index (0 = first edge that samples locked=1) after which
    // sys_rst_n is high, and after which ready / the init pulse appear.
    localparam int SYS_EDGE = SYNC + STABLE_N;
    localparam int RUN_EDGE = SYS_EDGE + POWER_N;

    typedef struct packed {
        logic       sys_rst_n;
        logic       init;
        logic       ready;
        logic       lost;
        logic [7:0] cnt;
    } obs_t;

    typedef struct packed {
        logic rst_n;
        logic locked;
        logic clear;
        obs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;

    pll_rst_seq_if bus ();

    pll_rst_seq #(
        .SYNC_STAGES    (SYNC),
        .STABLE_CYCLES  (STABLE_N),
        .POWERUP_CYCLES (POWER_N)
    ) dut (
        .CLOCK_100 (clk),
        .reset_n   (reset_n),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    obs_t  exp_q [$];
    string name_q [$];
    vec_t  vecs [18];

    function automatic obs_t mk(input logic s, input logic i, input logic r,
                                input logic l, input logic [7:0] c);
        obs_t o;
        o.sys_rst_n = s;
        o.init      = i;
        o.ready     = r;
        o.lost      = l;
        o.cnt       = c;
        return o;
    endfunction

    function automatic obs_t sample();
        return {bus.sys_rst_n, bus.sdram_init_start, bus.ready,
                bus.lock_lost, bus.lock_loss_count};
    endfunction

    // Drive one cycle of inputs; when chk is set, queue the expected
    // outputs and compare them against the DUT after the next rising edge.
    task automatic step(input logic rst_i, input logic lk_i, input logic clr_i,
                        input logic chk, input obs_t exp, input string nm);
        obs_t  got;
        obs_t  want;
        string cur;
        @(negedge clk);
        reset_n        = rst_i;
        bus.locked     = lk_i;
        bus.clear_lost = clr_i;
        if (chk) begin
            exp_q.push_back(exp);
            name_q.push_back(nm);
        end
        @(posedge clk);
        #1;
        if (chk) begin
            got  = sample();
            want = exp_q.pop_front();
            cur  = name_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s: got sys_rst_n=%b init=%b ready=%b lost=%b cnt=%0d, expected sys_rst_n=%b init=%b ready=%b lost=%b cnt=%0d",
                         cur, got.sys_rst_n, got.init, got.ready, got.lost, got.cnt,
                         want.sys_rst_n, want.init, want.ready, want.lost, want.cnt);
            end
        end
    endtask

    task automatic do_reset(input string nm);
        step(1'b0, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 8'd0), nm);
        step(1'b0, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 8'd0), nm);
    endtask

    // locked held high from edge 0 with a cleared synchronizer: full
    // bring-up latency, exactly one init pulse, loss bookkeeping untouched.
    task automatic expect_bringup(input logic lost, input logic [7:0] cnt, input string nm);
        for (int i = 0; i < RUN_EDGE + 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1,
                 mk(i >= SYS_EDGE, i == RUN_EDGE, i >= RUN_EDGE, lost, cnt),
                 $sformatf("%s[%0d]", nm, i));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        // Normal bring-up vectors: row 0 is reset, row 1 is the first edge
        // that samples locked=1.
        vecs[0]  = {1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 8'd0)};
        vecs[1]  = {1'b1, 1'b1, 1'b0, mk(0, 0, 0, 0, 8'd0)};
        vecs[2]  = {1'b1, 1'b1, 1'b0, mk(0, 0, 0, 0, 8'd0)};
        vecs[3]  = {1'b1, 1'b1, 1'b0, mk(0, 0, 0, 0, 8'd0)};
        vecs[4]  = {1'b1, 1'b1, 1'b0, mk(0, 0, 0, 0, 8'd0)};
        vecs[5]  = {1'b1, 1'b1, 1'b0, mk(0, 0, 0, 0, 8'd0)};
        vecs[6]  = {1'b1, 1'b1, 1'b0, mk(0, 0, 0, 0, 8'd0)};
        vecs[7]  = {1'b1, 1'b1, 1'b0, mk(1, 0, 0, 0, 8'd0)};
        vecs[8]  = {1'b1, 1'b1, 1'b0, mk(1, 0, 0, 0, 8'd0)};
        vecs[9]  = {1'b1, 1'b1, 1'b0, mk(1, 0, 0, 0, 8'd0)};
        vecs[10] = {1'b1, 1'b1, 1'b0, mk(1, 0, 0, 0, 8'd0)};
        vecs[11] = {1'b1, 1'b1, 1'b0, mk(1, 0, 0, 0, 8'd0)};
        vecs[12] = {1'b1, 1'b1, 1'b0, mk(1, 0, 0, 0, 8'd0)};
        vecs[13] = {1'b1, 1'b1, 1'b0, mk(1, 0, 0, 0, 8'd0)};
        vecs[14] = {1'b1, 1'b1, 1'b0, mk(1, 0, 0, 0, 8'd0)};
        vecs[15] = {1'b1, 1'b1, 1'b0, mk(1, 1, 1, 0, 8'd0)};
        vecs[16] = {1'b1, 1'b1, 1'b0, mk(1, 0, 1, 0, 8'd0)};
        vecs[17] = {1'b1, 1'b1, 1'b0, mk(1, 0, 1, 0, 8'd0)};

        reset_n        = 1'b0;
        bus.locked     = 1'b0;
        bus.clear_lost = 1'b0;

        // 1. Normal bring-up
        do_reset("reset");
        for (int i = 0; i < 18; i++) begin
            step(vecs[i].rst_n, vecs[i].locked, vecs[i].clear, 1'b1, vecs[i].exp,
                 $sformatf("bringup[%0d]", i));
        end

        // 3. Loss in RUN: response on the third edge after the drop, then relock
        step(1'b1, 1'b0, 1'b0, 1'b1, mk(1, 0, 1, 0, 8'd0), "run_loss_f0");
        step(1'b1, 1'b0, 1'b0, 1'b1, mk(1, 0, 1, 0, 8'd0), "run_loss_f1");
        step(1'b1, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 1, 8'd1), "run_loss_f2");
        step(1'b1, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 1, 8'd1), "run_loss_hold");
        expect_bringup(1'b1, 8'd1, "relock");

        // 2. Glitch in STABLE: high 3, low 1, then high; not counted
        do_reset("reset_glitch");
        step(1'b1, 1'b1, 1'b0, 1'b1, mk(0, 0, 0, 0, 8'd0), "glitch_h0");
        step(1'b1, 1'b1, 1'b0, 1'b1, mk(0, 0, 0, 0, 8'd0), "glitch_h1");
        step(1'b1, 1'b1, 1'b0, 1'b1, mk(0, 0, 0, 0, 8'd0), "glitch_h2");
        step(1'b1, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 8'd0), "glitch_low");
        expect_bringup(1'b0, 8'd0, "glitch_relock");

        // 4. Loss with POWERUP cnt=5 seen by the FSM: no init pulse ever
        do_reset("reset_pu_loss");
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1, mk(i >= SYS_EDGE, 0, 0, 0, 8'd0),
                 $sformatf("pu_loss_up[%0d]", i));
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, mk(1, 0, 0, 0, 8'd0), "pu_loss_f0");
        step(1'b1, 1'b0, 1'b0, 1'b1, mk(1, 0, 0, 0, 8'd0), "pu_loss_f1");
        step(1'b1, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 1, 8'd1), "pu_loss_f2");
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 1, 8'd1),
                 $sformatf("pu_loss_after[%0d]", i));
        end
        checks++;
        if (dut.state_q !== WAIT_LOCK) begin
            errors++;
            $display("FAIL pu_loss_state: got state=%0d, expected %0d",
                     dut.state_q, WAIT_LOCK);
        end

        // 5. 256 losses in POWERUP saturate at 255, then clear/loss collision
        do_reset("reset_sat");
        for (int k = 0; k < 257; k++) begin
            automatic logic       last = (k == 256);
            automatic logic [7:0] want = last ? 8'd1 : ((k + 1 > 255) ? 8'd255 : 8'(k + 1));
            for (int i = 0; i < SYS_EDGE + 1; i++) begin
                step(1'b1, 1'b1, 1'b0, i == SYS_EDGE,
                     mk(1, 0, 0, k != 0, (k > 255) ? 8'd255 : 8'(k)),
                     $sformatf("sat_up[%0d]", k));
            end
            step(1'b1, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 8'd0), "sat_f0");
            step(1'b1, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 8'd0), "sat_f1");
            step(1'b1, 1'b0, last, 1'b1, mk(0, 0, 0, 1, want),
                 $sformatf("sat_loss[%0d]", k));
        end
        step(1'b1, 1'b0, 1'b1, 1'b1, mk(0, 0, 0, 0, 8'd0), "clear_only");
        step(1'b1, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 8'd0), "clear_hold");

        // 6. Reset mid-POWERUP, then full-latency restart
        do_reset("reset_mid");
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1, mk(i >= SYS_EDGE, 0, 0, 0, 8'd0),
                 $sformatf("mid_up[%0d]", i));
        end
        step(1'b0, 1'b1, 1'b0, 1'b1, mk(0, 0, 0, 0, 8'd0), "mid_reset");
        expect_bringup(1'b0, 8'd0, "mid_restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pll_rst_seq
